xera4_vram_arbiter: RTL
=======================

Name: xera4_vram_arbiter

Overview:
- Shares the single-port 32 KB video RAM between three requesters: display line fetcher (burst reads), CPU video port, and blit DMA engine.
- Sits between the XERA4 CPU video bus, the display/DMA blocks, and the video SRAM.
- Provides fixed display priority with bounded CPU/DMA wait, round-robin between CPU and DMA, and tagged read-data return.

Parameters:
AW, 15, address width (video RAM words)
DW, 8, data width
BURST_MAX, 16, maximum display burst length in words
WAIT_MAX, 8, max cycles a pending CPU/DMA request may wait before a slot is forced

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
Dsp_req  in  1  display burst request, level
Dsp_Add  in  AW  burst start address
Dsp_len  in  5  burst length 1..BURST_MAX; 0 treated as 1; >BURST_MAX clamped
Dsp_gnt  out  1  one-cycle pulse per display word issued
Dsp_done  out  1  pulse coincident with Dsp_gnt of the last burst word
Dsp_rvalid  out  1  Rd_Data belongs to display
Cpu_req  in  1  CPU access request, level
Cpu_Add  in  AW  CPU address
Cpu_Out  in  DW  CPU write data
Cpu_we  in  1  1 = write, 0 = read
Cpu_gnt  out  1  one-cycle pulse, access issued
Cpu_rvalid  out  1  Rd_Data belongs to CPU
Dma_req, Dma_Add, Dma_Out, Dma_we, Dma_gnt, Dma_rvalid: same as the Cpu_ group
Rd_Data  out  DW  shared read-return data
Mem_Add  out  AW  SRAM address
Mem_Out  out  DW  SRAM write data
Mem_we  out  1  SRAM write enable
Mem_In  in  DW  SRAM read data, valid one cycle after address

Behaviour:
- Reset: all outputs 0, state IDLE, wait counter 0, round-robin pointer = DMA (so CPU wins the first tie), read pipeline tags cleared. In-flight reads are discarded; no rvalid after reset.
- Issue timing: at issuing edge E, the arbiter registers Mem_Add/Mem_Out/Mem_we and the matching *_gnt.
  - Mem_we is high for exactly one cycle per write.
  - For reads, Rd_Data and the tagged *_rvalid are registered at edge E+2 (2-cycle latency, fully pipelined, one access per cycle).
  - Writes produce no rvalid.
- Requester rule: hold req/Add/Out/we stable until gnt is seen. If req is still high in the cycle after gnt, it is a new access.
- Round-robin: the CPU/DMA winner is the requester not served last. If only one requests, it wins. The pointer updates on every CPU/DMA grant.
- Wait counter: increments each cycle Cpu_req|Dma_req is pending and not granted, saturates at WAIT_MAX, clears on any CPU/DMA grant. It is NOT cleared at burst end.
- State IDLE:
  - If counter==WAIT_MAX and CPU/DMA pending: grant the RR winner.
  - Else if Dsp_req: latch Dsp_Add and the clamped length, issue word 0. Go to BURST if len>1, else pulse Dsp_done and stay in IDLE.
  - Else if CPU/DMA pending: grant the RR winner.
  - Else Mem_we=0, no grant.
- State BURST:
  - Each cycle, issue the next display read; the address increments mod 2^AW (0x7FFF -> 0x0000).
  - When counter reaches WAIT_MAX with CPU/DMA pending, the next cycle goes to SLOT and the burst address/count are held.
  - On the last word: Dsp_done, go to IDLE.
- State SLOT: one CPU/DMA access (RR winner), counter cleared, return to BURST.
- Dsp_req is sampled only in IDLE. Deasserting it mid-burst has no effect; the burst always completes.
- Display accesses are reads only.
- Simultaneous Cpu_req and Dma_req in any granting cycle: RR decides; never both granted in one cycle.
- Reset asserted mid-burst or mid-slot: takes effect at the next edge as above; the burst is abandoned without Dsp_done.

Test Plan:
- Reset, then Cpu_req write Add=0x1234 data=0xA5, then CPU read 0x1234 -> Mem_we one cycle; read Cpu_rvalid at gnt edge+2 with Rd_Data=0xA5; Dma_rvalid/Dsp_rvalid stay 0.
- Cpu_req and Dma_req held continuously, both reading -> grants alternate CPU, DMA, CPU, DMA…; every cycle issues one access.
- Dsp_req Add=0x7FFE len=4, no other traffic -> Mem_Add 0x7FFE,0x7FFF,0x0000,0x0001 on consecutive cycles; Dsp_done with the 4th Dsp_gnt; four Dsp_rvalid pulses 2 cycles later.
- Display burst len=16 with Cpu_req raised at burst word 1 -> CPU granted after exactly WAIT_MAX=8 waiting cycles in a SLOT; burst resumes at the held address; total 17 issue cycles; Dsp_done on word 16.
- Dsp_req held high continuously with len=16 plus CPU pending -> CPU is granted at least once every WAIT_MAX+1 cycles across burst boundaries.
- rst pulsed during burst word 5, with a read outstanding -> no rvalid of any kind after reset; Dsp_done never pulses; next Dsp_req restarts from the newly latched address.

Source files
------------

// File: rtl/xera4_vram_arbiter.sv
// Video RAM arbiter: shares the single-port video SRAM between display bursts,
// the CPU video port and the blit DMA, with bounded CPU/DMA wait and tagged read return.
module xera4_vram_arbiter #(
  parameter int AW        = 15,
  parameter int DW        = 8,
  parameter int BURST_MAX = 16,
  parameter int WAIT_MAX  = 8
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          Dsp_req,
  input  logic [AW-1:0] Dsp_Add,
  input  logic [4:0]    Dsp_len,
  output logic          Dsp_gnt,
  output logic          Dsp_done,
  output logic          Dsp_rvalid,

  input  logic          Cpu_req,
  input  logic [AW-1:0] Cpu_Add,
  input  logic [DW-1:0] Cpu_Out,
  input  logic          Cpu_we,
  output logic          Cpu_gnt,
  output logic          Cpu_rvalid,

  input  logic          Dma_req,
  input  logic [AW-1:0] Dma_Add,
  input  logic [DW-1:0] Dma_Out,
  input  logic          Dma_we,
  output logic          Dma_gnt,
  output logic          Dma_rvalid,

  output logic [DW-1:0] Rd_Data,
  output logic [AW-1:0] Mem_Add,
  output logic [DW-1:0] Mem_Out,
  output logic          Mem_we,
  input  logic [DW-1:0] Mem_In
);

  localparam int            WW       = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(WAIT_MAX);
  localparam logic [4:0]    LEN_LIM  = 5'(BURST_MAX);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_SLOT} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_DSP, TAG_CPU, TAG_DMA} tag_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d, wait_inc;
  logic          rr_dma_q, rr_dma_d;
  logic [AW-1:0] baddr_q, baddr_d;
  logic [4:0]    bcnt_q, bcnt_d;
  logic [4:0]    len_c;

  logic [AW-1:0] mem_add_q, mem_add_d;
  logic [DW-1:0] mem_out_q, mem_out_d;
  logic          mem_we_q, mem_we_d;
  logic          dsp_gnt_q, dsp_gnt_d;
  logic          dsp_done_q, dsp_done_d;
  logic          cpu_gnt_q, cpu_gnt_d;
  logic          dma_gnt_q, dma_gnt_d;

  tag_t          tag1_q, tag1_d;
  tag_t          tag2_q, tag2_d;
  logic          dsp_rv_q, dsp_rv_d;
  logic          cpu_rv_q, cpu_rv_d;
  logic          dma_rv_q, dma_rv_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic          pend;
  logic          pick_cpu;
  logic          grant_rr;
  logic          cpu_win;
  logic          dma_win;

  assign pend     = Cpu_req | Dma_req;
  // rr_dma_q set means DMA was served last, so the CPU wins the next tie.
  assign pick_cpu = Cpu_req & (~Dma_req | rr_dma_q);
  assign wait_inc = (wait_q == WAIT_LIM) ? WAIT_LIM : wait_q + WW'(1);

  always_comb begin
    if (Dsp_len == 5'd0) begin
      len_c = 5'd1;
    end else if (Dsp_len > LEN_LIM) begin
      len_c = LEN_LIM;
    end else begin
      len_c = Dsp_len;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    rr_dma_d   = rr_dma_q;
    baddr_d    = baddr_q;
    bcnt_d     = bcnt_q;
    mem_add_d  = mem_add_q;
    mem_out_d  = mem_out_q;
    mem_we_d   = 1'b0;
    dsp_gnt_d  = 1'b0;
    dsp_done_d = 1'b0;
    cpu_gnt_d  = 1'b0;
    dma_gnt_d  = 1'b0;
    tag1_d     = TAG_NONE;
    tag2_d     = tag1_q;
    dsp_rv_d   = (tag2_q == TAG_DSP);
    cpu_rv_d   = (tag2_q == TAG_CPU);
    dma_rv_d   = (tag2_q == TAG_DMA);
    rd_data_d  = (tag2_q != TAG_NONE) ? Mem_In : rd_data_q;
    grant_rr   = 1'b0;
    cpu_win    = 1'b0;
    dma_win    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if ((wait_q == WAIT_LIM) && pend) begin
          grant_rr = 1'b1;
        end else if (Dsp_req) begin
          mem_add_d = Dsp_Add;
          dsp_gnt_d = 1'b1;
          tag1_d    = TAG_DSP;
          if (len_c > 5'd1) begin
            baddr_d = Dsp_Add + AW'(1);
            bcnt_d  = len_c - 5'd1;
            state_d = S_BURST;
          end else begin
            dsp_done_d = 1'b1;
          end
        end else if (pend) begin
          grant_rr = 1'b1;
        end
      end
      S_BURST: begin
        mem_add_d = baddr_q;
        dsp_gnt_d = 1'b1;
        tag1_d    = TAG_DSP;
        baddr_d   = baddr_q + AW'(1);
        bcnt_d    = bcnt_q - 5'd1;
        if (bcnt_q == 5'd1) begin
          dsp_done_d = 1'b1;
          state_d    = S_IDLE;
        end else if (pend && (wait_inc == WAIT_LIM)) begin
          state_d = S_SLOT;
        end
      end
      S_SLOT: begin
        grant_rr = 1'b1;
        state_d  = S_BURST;
      end
      default: state_d = S_IDLE;
    endcase

    if (grant_rr && pend) begin
      cpu_win = pick_cpu;
      dma_win = ~pick_cpu;
    end

    if (cpu_win) begin
      mem_add_d = Cpu_Add;
      mem_out_d = Cpu_Out;
      mem_we_d  = Cpu_we;
      cpu_gnt_d = 1'b1;
      rr_dma_d  = 1'b0;
      tag1_d    = Cpu_we ? TAG_NONE : TAG_CPU;
    end else if (dma_win) begin
      mem_add_d = Dma_Add;
      mem_out_d = Dma_Out;
      mem_we_d  = Dma_we;
      dma_gnt_d = 1'b1;
      rr_dma_d  = 1'b1;
      tag1_d    = Dma_we ? TAG_NONE : TAG_DMA;
    end

    // The wait counter survives burst boundaries so a CPU/DMA slot cannot be starved.
    if (cpu_win || dma_win) begin
      wait_d = '0;
    end else if (pend) begin
      wait_d = wait_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      rr_dma_q   <= 1'b1;
      baddr_q    <= '0;
      bcnt_q     <= '0;
      mem_add_q  <= '0;
      mem_out_q  <= '0;
      mem_we_q   <= 1'b0;
      dsp_gnt_q  <= 1'b0;
      dsp_done_q <= 1'b0;
      cpu_gnt_q  <= 1'b0;
      dma_gnt_q  <= 1'b0;
      tag1_q     <= TAG_NONE;
      tag2_q     <= TAG_NONE;
      dsp_rv_q   <= 1'b0;
      cpu_rv_q   <= 1'b0;
      dma_rv_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rr_dma_q   <= rr_dma_d;
      baddr_q    <= baddr_d;
      bcnt_q     <= bcnt_d;
      mem_add_q  <= mem_add_d;
      mem_out_q  <= mem_out_d;
      mem_we_q   <= mem_we_d;
      dsp_gnt_q  <= dsp_gnt_d;
      dsp_done_q <= dsp_done_d;
      cpu_gnt_q  <= cpu_gnt_d;
      dma_gnt_q  <= dma_gnt_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
      dsp_rv_q   <= dsp_rv_d;
      cpu_rv_q   <= cpu_rv_d;
      dma_rv_q   <= dma_rv_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign Mem_Add    = mem_add_q;
  assign Mem_Out    = mem_out_q;
  assign Mem_we     = mem_we_q;
  assign Dsp_gnt    = dsp_gnt_q;
  assign Dsp_done   = dsp_done_q;
  assign Cpu_gnt    = cpu_gnt_q;
  assign Dma_gnt    = dma_gnt_q;
  assign Dsp_rvalid = dsp_rv_q;
  assign Cpu_rvalid = cpu_rv_q;
  assign Dma_rvalid = dma_rv_q;
  assign Rd_Data    = rd_data_q;

endmodule
